// File: rtl/split_gen.sv
// split_gen: splits a packed polynomial into two fragments, either by
// even/odd de-interleave (mode 0) or at a coefficient index (mode 1).
// LANES coefficients are routed per cycle. Coefficient i occupies bits
// [i*COEF_W : i*COEF_W+COEF_W-1] of the ascending-range data ports.
// Optional macro SPLIT_DEG_EN adds degree and all-zero status outputs.
module split_gen #(
    parameter int COEF_W   = 16,
    parameter int COEF_NUM = 9,
    parameter int LANES    = 1,
    localparam int DAT_W   = COEF_W * COEF_NUM,
    localparam int POS_W   = $clog2(COEF_NUM + 1),
    localparam int DEG_W   = (COEF_NUM > 1) ? $clog2(COEF_NUM) : 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic             mode,
    input  logic [POS_W-1:0] split_pos,
    input  logic [0:DAT_W-1] poly_in,
    output logic             busy,
    output logic             split_done,
    output logic [0:DAT_W-1] first_fragment_out,
    output logic [0:DAT_W-1] second_fragment_out
`ifdef SPLIT_DEG_EN
    ,
    output logic [DEG_W-1:0] first_deg,
    output logic [DEG_W-1:0] second_deg,
    output logic             first_zero,
    output logic             second_zero
`endif
);

    localparam int NBAT  = (COEF_NUM + LANES - 1) / LANES;
    localparam int CNT_W = $clog2(NBAT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bat_q, bat_d;
    logic              mode_q, mode_d;
    logic [POS_W-1:0]  k_q, k_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [0:DAT_W-1]  first_frag_q, first_frag_d;
    logic [0:DAT_W-1]  second_frag_q, second_frag_d;
    logic [COEF_W-1:0] poly_w_q   [COEF_NUM];
    logic [COEF_W-1:0] poly_w_d   [COEF_NUM];
    logic [COEF_W-1:0] first_w_q  [COEF_NUM];
    logic [COEF_W-1:0] first_w_d  [COEF_NUM];
    logic [COEF_W-1:0] second_w_q [COEF_NUM];
    logic [COEF_W-1:0] second_w_d [COEF_NUM];
    int unsigned       base_idx;
`ifdef SPLIT_DEG_EN
    logic [DEG_W-1:0]  first_deg_q, first_deg_d;
    logic [DEG_W-1:0]  second_deg_q, second_deg_d;
    logic              first_zero_q, first_zero_d;
    logic              second_zero_q, second_zero_d;
`endif

    assign base_idx = 32'(bat_q) * 32'(LANES);

    // Next-state: accept, per-batch routing into working slots, result publish
    always_comb begin
        state_d       = state_q;
        bat_d         = bat_q;
        mode_d        = mode_q;
        k_d           = k_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        first_frag_d  = first_frag_q;
        second_frag_d = second_frag_q;
        poly_w_d      = poly_w_q;
        first_w_d     = first_w_q;
        second_w_d    = second_w_q;
`ifdef SPLIT_DEG_EN
        first_deg_d   = first_deg_q;
        second_deg_d  = second_deg_q;
        first_zero_d  = first_zero_q;
        second_zero_d = second_zero_q;
`endif
        case (state_q)
            ST_RUN: begin
                for (int unsigned l = 0; l < LANES; l++) begin
                    if (base_idx + l < COEF_NUM) begin
                        if (!mode_q) begin
                            if (((base_idx + l) & 32'd1) == 32'd0)
                                first_w_d[DEG_W'((base_idx + l) >> 1)] = poly_w_q[DEG_W'(base_idx + l)];
                            else
                                second_w_d[DEG_W'((base_idx + l) >> 1)] = poly_w_q[DEG_W'(base_idx + l)];
                        end else begin
                            if (base_idx + l < 32'(k_q))
                                first_w_d[DEG_W'(base_idx + l)] = poly_w_q[DEG_W'(base_idx + l)];
                            else
                                second_w_d[DEG_W'(base_idx + l - 32'(k_q))] = poly_w_q[DEG_W'(base_idx + l)];
                        end
                    end
                end
                if (bat_q == CNT_W'(NBAT - 1)) begin
                    // Final batch: publish straight from the updated working slots
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    for (int unsigned i = 0; i < COEF_NUM; i++) begin
                        first_frag_d[i*COEF_W +: COEF_W]  = first_w_d[i];
                        second_frag_d[i*COEF_W +: COEF_W] = second_w_d[i];
                    end
`ifdef SPLIT_DEG_EN
                    first_deg_d   = '0;
                    second_deg_d  = '0;
                    first_zero_d  = 1'b1;
                    second_zero_d = 1'b1;
                    for (int unsigned i = 0; i < COEF_NUM; i++) begin
                        if (first_w_d[i] != '0) begin
                            first_deg_d  = DEG_W'(i);
                            first_zero_d = 1'b0;
                        end
                        if (second_w_d[i] != '0) begin
                            second_deg_d  = DEG_W'(i);
                            second_zero_d = 1'b0;
                        end
                    end
`endif
                end else begin
                    bat_d = bat_q + CNT_W'(1);
                end
            end
            default: begin
                // IDLE and DONE both accept a new request
                if (start) begin
                    state_d = ST_RUN;
                    busy_d  = 1'b1;
                    bat_d   = '0;
                    mode_d  = mode;
                    k_d     = (split_pos > POS_W'(COEF_NUM)) ? POS_W'(COEF_NUM) : split_pos;
                    for (int unsigned i = 0; i < COEF_NUM; i++) begin
                        poly_w_d[i]   = poly_in[i*COEF_W +: COEF_W];
                        first_w_d[i]  = '0;
                        second_w_d[i] = '0;
                    end
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            end
        endcase
    end

    // State, working and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q       <= ST_IDLE;
            bat_q         <= '0;
            mode_q        <= 1'b0;
            k_q           <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            first_frag_q  <= '0;
            second_frag_q <= '0;
            poly_w_q      <= '{default: '0};
            first_w_q     <= '{default: '0};
            second_w_q    <= '{default: '0};
`ifdef SPLIT_DEG_EN
            first_deg_q   <= '0;
            second_deg_q  <= '0;
            first_zero_q  <= 1'b0;
            second_zero_q <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            bat_q         <= bat_d;
            mode_q        <= mode_d;
            k_q           <= k_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            first_frag_q  <= first_frag_d;
            second_frag_q <= second_frag_d;
            poly_w_q      <= poly_w_d;
            first_w_q     <= first_w_d;
            second_w_q    <= second_w_d;
`ifdef SPLIT_DEG_EN
            first_deg_q   <= first_deg_d;
            second_deg_q  <= second_deg_d;
            first_zero_q  <= first_zero_d;
            second_zero_q <= second_zero_d;
`endif
        end
    end

    assign busy                = busy_q;
    assign split_done          = done_q;
    assign first_fragment_out  = first_frag_q;
    assign second_fragment_out = second_frag_q;
`ifdef SPLIT_DEG_EN
    assign first_deg   = first_deg_q;
    assign second_deg  = second_deg_q;
    assign first_zero  = first_zero_q;
    assign second_zero = second_zero_q;
`endif

endmodule

// File: tb/tb_split_gen.sv
// Directed self-checking bench for split_gen: a LANES=1 instance and a
// LANES=4 instance share operands; sel picks which one is driven/observed.
module tb_split_gen;

    localparam int DW = 144;

    logic          clk = 1'b0;
    logic          rst_b = 1'b0;
    logic          start = 1'b0;
    logic          sel = 1'b0;
    logic          mode = 1'b0;
    logic [3:0]    split_pos = '0;
    logic [0:DW-1] poly_in = '0;

    logic          busy1, done1, busy4, done4;
    logic [0:DW-1] f1, s1, f4, s4;
    logic          start1, start4;
    logic          o_busy, o_done;
    logic [0:DW-1] o_f, o_s;
`ifdef SPLIT_DEG_EN
    logic [3:0]    fd1, sd1, fd4, sd4, o_fd, o_sd;
    logic          fz1, sz1, fz4, sz4, o_fz, o_sz;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    logic [0:DW-1] prev_f [2];
    logic [0:DW-1] prev_s [2];

    always #5 clk = ~clk;

    assign start1 = start & ~sel;
    assign start4 = start & sel;
    assign o_busy = sel ? busy4 : busy1;
    assign o_done = sel ? done4 : done1;
    assign o_f    = sel ? f4 : f1;
    assign o_s    = sel ? s4 : s1;
`ifdef SPLIT_DEG_EN
    assign o_fd = sel ? fd4 : fd1;
    assign o_sd = sel ? sd4 : sd1;
    assign o_fz = sel ? fz4 : fz1;
    assign o_sz = sel ? sz4 : sz1;
`endif

    split_gen #(.COEF_W(16), .COEF_NUM(9), .LANES(1)) dut (
        .clk(clk), .rst_b(rst_b), .start(start1), .mode(mode),
        .split_pos(split_pos), .poly_in(poly_in), .busy(busy1),
        .split_done(done1), .first_fragment_out(f1), .second_fragment_out(s1)
`ifdef SPLIT_DEG_EN
        , .first_deg(fd1), .second_deg(sd1), .first_zero(fz1), .second_zero(sz1)
`endif
    );

    split_gen #(.COEF_W(16), .COEF_NUM(9), .LANES(4)) dut4 (
        .clk(clk), .rst_b(rst_b), .start(start4), .mode(mode),
        .split_pos(split_pos), .poly_in(poly_in), .busy(busy4),
        .split_done(done4), .first_fragment_out(f4), .second_fragment_out(s4)
`ifdef SPLIT_DEG_EN
        , .first_deg(fd4), .second_deg(sd4), .first_zero(fz4), .second_zero(sz4)
`endif
    );

    task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [0:DW-1] pk(input logic [15:0] a0, a1, a2, a3, a4,
                                         a5, a6, a7, a8);
        logic [0:DW-1] v;
        v[0:15]    = a0; v[16:31]   = a1; v[32:47]   = a2;
        v[48:63]   = a3; v[64:79]   = a4; v[80:95]   = a5;
        v[96:111]  = a6; v[112:127] = a7; v[128:143] = a8;
        return v;
    endfunction

    // Launch one request, measure latency, busy span and the published result
    task automatic run_op(input logic m, input logic [3:0] pos,
                          input logic [0:DW-1] ef, input logic [0:DW-1] es,
                          input int lat, input bit restart_mid,
                          input int efd, input int esd, input bit efz, input bit esz);
        int n;
        int busy_cnt;
        mode = m;
        split_pos = pos;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        busy_cnt = 0;
        while (!o_done && n < 40) begin
            if (o_busy) busy_cnt++;
            if (n == 5) begin
                check_eq("hold_first", 256'(o_f), 256'(prev_f[sel]));
                check_eq("hold_second", 256'(o_s), 256'(prev_s[sel]));
            end
            start = (restart_mid && n == 4);
            tick();
            start = 1'b0;
            n++;
        end
        check_eq("latency", 256'(n), 256'(lat));
        check_eq("busy_span", 256'(busy_cnt), 256'(lat - 1));
        check_eq("busy_at_done", 256'(o_busy), 256'(0));
        check_eq("first_frag", 256'(o_f), 256'(ef));
        check_eq("second_frag", 256'(o_s), 256'(es));
`ifdef SPLIT_DEG_EN
        check_eq("first_deg", 256'(o_fd), 256'(efd));
        check_eq("second_deg", 256'(o_sd), 256'(esd));
        check_eq("first_zero", 256'(o_fz), 256'(efz));
        check_eq("second_zero", 256'(o_sz), 256'(esz));
`endif
        prev_f[sel] = ef;
        prev_s[sel] = es;
    endtask

    // Idle for n cycles: no stray completion, fragments must hold
    task automatic idle(input int n);
        int extra;
        extra = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (o_done) extra++;
        end
        check_eq("no_extra_done", 256'(extra), 256'(0));
        check_eq("idle_first_hold", 256'(o_f), 256'(prev_f[sel]));
    endtask

    logic [0:DW-1] p, z, m0f, m0s, k3f, k3s;

    initial begin
        p   = pk(16'h2F78, 16'h093A, 16'hCE98, 16'h7914, 16'h206A, 16'h035C, 16'h9CFE, 16'hA1C4, 16'h4746);
        z   = '0;
        m0f = pk(16'h2F78, 16'hCE98, 16'h206A, 16'h9CFE, 16'h4746, 16'h0, 16'h0, 16'h0, 16'h0);
        m0s = pk(16'h093A, 16'h7914, 16'h035C, 16'hA1C4, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        k3f = pk(16'h2F78, 16'h093A, 16'hCE98, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        k3s = pk(16'h7914, 16'h206A, 16'h035C, 16'h9CFE, 16'hA1C4, 16'h4746, 16'h0, 16'h0, 16'h0);
        prev_f[0] = '0; prev_s[0] = '0; prev_f[1] = '0; prev_s[1] = '0;
        poly_in = p;

        tick(); tick();
        check_eq("rst_busy", 256'(busy1), 256'(0));
        check_eq("rst_done", 256'(done1), 256'(0));
        check_eq("rst_first", 256'(f1), 256'(0));
        check_eq("rst_second", 256'(s1), 256'(0));
        rst_b = 1'b1;
        tick();

        run_op(1'b0, 4'd0,  m0f, m0s, 10, 1'b0, 4, 3, 1'b0, 1'b0);
        idle(3);
        run_op(1'b1, 4'd3,  k3f, k3s, 10, 1'b0, 2, 5, 1'b0, 1'b0);
        idle(2);
        run_op(1'b1, 4'd0,  z,   p,   10, 1'b0, 0, 8, 1'b1, 1'b0);
        idle(2);
        run_op(1'b1, 4'd15, p,   z,   10, 1'b0, 8, 0, 1'b0, 1'b1);
        idle(2);
        run_op(1'b0, 4'd0,  m0f, m0s, 10, 1'b1, 4, 3, 1'b0, 1'b0);
        idle(12);

        // Abort mid-run with reset
        mode = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst_b = 1'b0;
        #1;
        check_eq("abort_busy", 256'(busy1), 256'(0));
        check_eq("abort_done", 256'(done1), 256'(0));
        check_eq("abort_first", 256'(f1), 256'(0));
        check_eq("abort_second", 256'(s1), 256'(0));
        prev_f[0] = '0; prev_s[0] = '0; prev_f[1] = '0; prev_s[1] = '0;
        tick(); tick();
        rst_b = 1'b1;
        idle(12);
        run_op(1'b1, 4'd3, k3f, k3s, 10, 1'b0, 2, 5, 1'b0, 1'b0);
        idle(2);

        // Four lanes, then a back-to-back request in the completion cycle
        sel = 1'b1;
        tick();
        run_op(1'b0, 4'd0, m0f, m0s, 4, 1'b0, 4, 3, 1'b0, 1'b0);
        run_op(1'b1, 4'd3, k3f, k3s, 4, 1'b0, 2, 5, 1'b0, 1'b0);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
